// File: rtl/spi_master_arb.sv
// spi_master_arb
// Two-requester SPI master (mode 0, MSB first, 8-bit transfers) with
// round-robin arbitration.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   req[1:0]  level transfer request per requester
//   tx_data0  byte for requester 0, captured at grant
//   tx_data1  byte for requester 1, captured at grant
//   grant     one-hot bus owner, 2'b00 when idle
//   done      one-cycle completion pulse for the owner
//   rx_data   last received byte, updated with done
//   busy      high whenever the FSM is not IDLE
//   CS        active-low chip selects, CS[g] for requester g
//   SCLK      SPI clock, idles low
//   MOSI      serial data out
//   MISO      serial data in
//
// Parameter CLK_DIV (1..255) is the SCLK half-period in clk cycles.
// Every non-IDLE state lasts exactly CLK_DIV cycles, so a transfer is
// SETUP + 8 HIGH + 7 LOW + HOLD = 17 phases with CS low throughout.
module spi_master_arb #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [7:0] tx_data0,
  input  logic [7:0] tx_data1,
  output logic [1:0] grant,
  output logic [1:0] done,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic [1:0] CS,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO
);

  localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t     state_reg,   state_next;
  logic [7:0] div_reg,     div_next;
  logic [3:0] bit_reg,     bit_next;
  logic [7:0] tx_reg,      tx_next;
  logic [7:0] rx_reg,      rx_next;
  logic [7:0] rx_data_reg, rx_data_next;
  logic [1:0] grant_reg,   grant_next;
  logic [1:0] done_reg,    done_next;
  logic       sclk_reg,    sclk_next;
  logic       mosi_reg,    mosi_next;
  // Index of the most recently granted requester; resets to 1 so that
  // requester 0 wins the first contested arbitration.
  logic       last_reg,    last_next;

  logic       div_last;
  logic       pick;
  logic [7:0] sel_byte;

  assign div_last = (div_reg == DIV_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      div_reg     <= 8'd0;
      bit_reg     <= 4'd0;
      tx_reg      <= 8'd0;
      rx_reg      <= 8'd0;
      rx_data_reg <= 8'd0;
      grant_reg   <= 2'b00;
      done_reg    <= 2'b00;
      sclk_reg    <= 1'b0;
      mosi_reg    <= 1'b0;
      last_reg    <= 1'b1;
    end else begin
      state_reg   <= state_next;
      div_reg     <= div_next;
      bit_reg     <= bit_next;
      tx_reg      <= tx_next;
      rx_reg      <= rx_next;
      rx_data_reg <= rx_data_next;
      grant_reg   <= grant_next;
      done_reg    <= done_next;
      sclk_reg    <= sclk_next;
      mosi_reg    <= mosi_next;
      last_reg    <= last_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_next     = bit_reg;
    tx_next      = tx_reg;
    rx_next      = rx_reg;
    rx_data_next = rx_data_reg;
    grant_next   = grant_reg;
    done_next    = 2'b00;
    sclk_next    = sclk_reg;
    mosi_next    = mosi_reg;
    last_next    = last_reg;
    pick         = 1'b0;
    sel_byte     = 8'd0;
    // Divider free-runs 0..CLK_DIV-1 in every non-IDLE state and wraps
    // exactly when the state advances.
    div_next     = div_last ? 8'd0 : div_reg + 8'd1;

    case (state_reg)
      IDLE: begin
        div_next = 8'd0;
        if (|req) begin
          // Contested: the one not granted last time wins.
          pick       = (req == 2'b11) ? ~last_reg : req[1];
          sel_byte   = pick ? tx_data1 : tx_data0;
          grant_next = pick ? 2'b10 : 2'b01;
          tx_next    = sel_byte;
          mosi_next  = sel_byte[7];
          bit_next   = 4'd0;
          rx_next    = 8'd0;
          state_next = SETUP;
        end
      end

      SETUP, LOW: begin
        if (div_last) begin
          sclk_next  = 1'b1;
          rx_next    = {rx_reg[6:0], MISO};
          bit_next   = bit_reg + 4'd1;
          state_next = HIGH;
        end
      end

      HIGH: begin
        if (div_last) begin
          sclk_next = 1'b0;
          if (bit_reg == 4'd8) begin
            state_next = HOLD;
          end else begin
            tx_next    = {tx_reg[6:0], 1'b0};
            mosi_next  = tx_reg[6];
            state_next = LOW;
          end
        end
      end

      HOLD: begin
        if (div_last) begin
          grant_next   = 2'b00;
          rx_data_next = rx_reg;
          done_next    = grant_reg;
          last_next    = grant_reg[1];
          state_next   = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        grant_next = 2'b00;
        sclk_next  = 1'b0;
      end
    endcase
  end

  // Chip selects are the inverted grant, so grant == ~CS by construction
  // and at most one select can be low.
  assign grant   = grant_reg;
  assign CS      = ~grant_reg;
  assign done    = done_reg;
  assign rx_data = rx_data_reg;
  assign busy    = (state_reg != IDLE);
  assign SCLK    = sclk_reg;
  assign MOSI    = mosi_reg;

endmodule
